sd_read_arbiter: RTL and testbench
==================================

Name: sd_read_arbiter

Overview:
- Shares the single SDCard_reader block-read interface between two requesters: client 0 (FAT32_reader) and client 1 (e.g. a future playlist/metadata scanner).
- Sits between the clients and SDCard_reader. Presents each client the same trigger / continuous / addr / ready / data / idx / new_flag handshake the card reader exposes, so clients need no changes.
- Grants whole transactions (single block, or a full continuous run), alternating priority round-robin.

Parameters:
- SD_BLOCK_ADDR_BITS, 32, block address width (same value as the codebase constant).
- SD_BLOCK_LENGHT_BITS, 9, byte index width within a 512-byte block.
- GRANT_TIMEOUT, 255, cycles allowed in GRANT for card_ready to fall before the grant is revoked.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- c0_trigger / c1_trigger  in  1  client read request
- c0_continous_mode / c1_continous_mode  in  1  client multi-block mode
- c0_block_addr / c1_block_addr  in  SD_BLOCK_ADDR_BITS  client start address
- c0_card_ready / c1_card_ready  out  1  per-client ready view
- c0_data_new_flag / c1_data_new_flag  out  1  per-client byte strobe
- client_data  out  8  broadcast byte
- client_data_idx  out  SD_BLOCK_LENGHT_BITS  broadcast byte index
- block_read_trigger  out  1  to card reader
- block_read_continous_mode  out  1  to card reader
- block_read_block_addr  out  SD_BLOCK_ADDR_BITS  to card reader
- block_read_card_ready  in  1  from card reader
- block_read_data_in  in  8  from card reader
- block_read_data_idx  in  SD_BLOCK_LENGHT_BITS  from card reader
- block_read_data_new_flag  in  1  from card reader
- owner  out  2  00 none, 01 client0, 10 client1
- arb_timeout  out  1  sticky, set on any grant revoke by timeout

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, including mid-transaction; no attempt is made to complete the in-flight card transfer:
  - state=IDLE, owner=00, init_done=0, prio=0, timeout counter=0, arb_timeout=0.
  - block_read_trigger=0, block_read_continous_mode=0, block_read_block_addr=0.
- init_done sets on the first cycle block_read_card_ready=1 after reset and stays set until the next reset.
- Per-client ready view:
  - If the client is the owner: cN_card_ready = block_read_card_ready.
  - Else if init_done=0: cN_card_ready = block_read_card_ready.
  - Else: cN_card_ready = 1. A stalled loser keeps seeing ready and keeps its trigger asserted.
- Data return:
  - cN_data_new_flag = block_read_data_new_flag AND owner==N. Non-owners always see 0.
  - client_data and client_data_idx are combinational pass-throughs of block_read_data_in and block_read_data_idx.
- Downstream muxing: block_read_trigger, continous_mode and block_addr are combinational from the owner's inputs. With owner=00 all three are 0.
- FSM: IDLE, GRANT, BUSY.
  - IDLE: when block_read_card_ready=1 and any trigger is high, register the owner and go to GRANT. The grant is visible one cycle after trigger is sampled.
    - Only one trigger high: that client wins.
    - Both high: client prio wins.
  - GRANT: wait for the card to accept the request.
    - block_read_card_ready=0: go to BUSY, clear the timeout counter.
    - Else if the owner's trigger=0 (request abandoned): release to IDLE, prio unchanged.
    - Else if the counter reaches GRANT_TIMEOUT-1: release to IDLE, set arb_timeout.
    - Otherwise increment the counter.
  - BUSY: hold the owner. Owner trigger changes are forwarded, so a continuous run is ended by the client dropping its trigger. On block_read_card_ready 0→1, release to IDLE and set prio = the non-owner.
- Release: owner=00 on the cycle IDLE is re-entered. A new grant can be issued in that same IDLE cycle.
- Back-to-back: a client re-triggering while the other is waiting loses (round-robin). No starvation: with both clients requesting continuously, grants strictly alternate.
- No combinational path from any cN_trigger to cN_card_ready.

Test Plan:
- After reset with card_ready low for 10 cycles, then high: both clients see ready follow the card until the first high; after that owner=00 and non-owners see ready=1.
- c0 single read at addr 0x0000_1000: owner=01 one cycle after trigger, block_read_block_addr=0x1000. 512 new_flags reach c0 only; c1_data_new_flag stays 0. Release on ready rise; prio becomes 1.
- c0 and c1 trigger in the same cycle after reset: c0 granted (prio=0); c1 sees ready=1 and remains triggering; c1 granted in the IDLE cycle after c0 completes, with its own address forwarded.
- c1 continuous read of 4 blocks, dropping trigger during the last block: owner stays 10 across all 2048 strobes; c0 is blocked throughout; release occurs only at the final ready rise.
- Card model holds ready=1 and ignores the trigger: release after 255 GRANT cycles, arb_timeout=1 and stays 1; the other client is grantable next.
- rst asserted mid-BUSY at byte 100: the next cycle gives owner=00, all block_read_* outputs 0, arb_timeout=0, and the FSM restarts cleanly.

Source files
------------

// File: rtl/sd_read_arbiter.sv
// Shares one SDCard_reader block-read port between two clients, granting whole
// transactions with round-robin priority. Each client sees the reader's own handshake.
module sd_read_arbiter #(
    parameter int unsigned SD_BLOCK_ADDR_BITS   = 32,
    parameter int unsigned SD_BLOCK_LENGHT_BITS = 9,
    parameter int unsigned GRANT_TIMEOUT        = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    // client 0
    input  logic                            c0_trigger,
    input  logic                            c0_continous_mode,
    input  logic [SD_BLOCK_ADDR_BITS-1:0]   c0_block_addr,
    output logic                            c0_card_ready,
    output logic                            c0_data_new_flag,
    // client 1
    input  logic                            c1_trigger,
    input  logic                            c1_continous_mode,
    input  logic [SD_BLOCK_ADDR_BITS-1:0]   c1_block_addr,
    output logic                            c1_card_ready,
    output logic                            c1_data_new_flag,
    // broadcast return data
    output logic [7:0]                      client_data,
    output logic [SD_BLOCK_LENGHT_BITS-1:0] client_data_idx,
    // card reader side
    output logic                            block_read_trigger,
    output logic                            block_read_continous_mode,
    output logic [SD_BLOCK_ADDR_BITS-1:0]   block_read_block_addr,
    input  logic                            block_read_card_ready,
    input  logic [7:0]                      block_read_data_in,
    input  logic [SD_BLOCK_LENGHT_BITS-1:0] block_read_data_idx,
    input  logic                            block_read_data_new_flag,
    // status
    output logic [1:0]                      owner,
    output logic                            arb_timeout
);

    localparam int unsigned CntW = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(GRANT_TIMEOUT - 1);

    localparam logic [1:0] OwnNone = 2'b00;
    localparam logic [1:0] Own0    = 2'b01;
    localparam logic [1:0] Own1    = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGrant = 2'b01,
        StBusy  = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic            init_done_q, init_done_d;
    logic            prio_q, prio_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            arb_timeout_q, arb_timeout_d;
    logic            ready_q, ready_d;

    logic own0, own1;
    logic owner_trigger;
    logic ready_rise;

    assign own0 = (owner_q == Own0);
    assign own1 = (owner_q == Own1);

    assign owner_trigger = (own0 & c0_trigger) | (own1 & c1_trigger);
    assign ready_rise    = block_read_card_ready & ~ready_q;

    // Before the card first reports ready, everyone sees the real ready so
    // clients wait out card initialisation exactly as without the arbiter.
    assign c0_card_ready = (own0 || !init_done_q) ? block_read_card_ready : 1'b1;
    assign c1_card_ready = (own1 || !init_done_q) ? block_read_card_ready : 1'b1;

    assign c0_data_new_flag = block_read_data_new_flag & own0;
    assign c1_data_new_flag = block_read_data_new_flag & own1;

    assign client_data     = block_read_data_in;
    assign client_data_idx = block_read_data_idx;

    always_comb begin
        block_read_trigger        = 1'b0;
        block_read_continous_mode = 1'b0;
        block_read_block_addr     = '0;
        if (own0) begin
            block_read_trigger        = c0_trigger;
            block_read_continous_mode = c0_continous_mode;
            block_read_block_addr     = c0_block_addr;
        end else if (own1) begin
            block_read_trigger        = c1_trigger;
            block_read_continous_mode = c1_continous_mode;
            block_read_block_addr     = c1_block_addr;
        end
    end

    assign owner       = owner_q;
    assign arb_timeout = arb_timeout_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        prio_d        = prio_q;
        cnt_d         = cnt_q;
        arb_timeout_d = arb_timeout_q;
        init_done_d   = init_done_q | block_read_card_ready;
        ready_d       = block_read_card_ready;

        unique case (state_q)
            StIdle: begin
                if (block_read_card_ready && (c0_trigger || c1_trigger)) begin
                    state_d = StGrant;
                    cnt_d   = '0;
                    if (c0_trigger && c1_trigger) begin
                        owner_d = prio_q ? Own1 : Own0;
                    end else begin
                        owner_d = c0_trigger ? Own0 : Own1;
                    end
                end
            end
            StGrant: begin
                if (!block_read_card_ready) begin
                    state_d = StBusy;
                    cnt_d   = '0;
                end else if (!owner_trigger) begin
                    // request abandoned before the card took it: priority untouched
                    state_d = StIdle;
                    owner_d = OwnNone;
                end else if (cnt_q == CntLast) begin
                    state_d       = StIdle;
                    owner_d       = OwnNone;
                    cnt_d         = '0;
                    arb_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBusy: begin
                if (ready_rise) begin
                    state_d = StIdle;
                    owner_d = OwnNone;
                    prio_d  = own0;
                end
            end
            default: begin
                state_d = StIdle;
                owner_d = OwnNone;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            owner_q       <= OwnNone;
            init_done_q   <= 1'b0;
            prio_q        <= 1'b0;
            cnt_q         <= '0;
            arb_timeout_q <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            init_done_q   <= init_done_d;
            prio_q        <= prio_d;
            cnt_q         <= cnt_d;
            arb_timeout_q <= arb_timeout_d;
            ready_q       <= ready_d;
        end
    end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Bench for sd_read_arbiter: behavioural card, two client agents and a transaction-level
// reference of who holds the card, compared every cycle against the DUT.
module tb_sd_read_arbiter;

    localparam int AW = 32;
    localparam int LW = 9;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          c0_trigger = 1'b0, c1_trigger = 1'b0;
    logic          c0_continous_mode = 1'b0, c1_continous_mode = 1'b0;
    logic [AW-1:0] c0_block_addr = '0, c1_block_addr = '0;
    logic          c0_card_ready, c1_card_ready;
    logic          c0_data_new_flag, c1_data_new_flag;
    logic [7:0]    client_data;
    logic [LW-1:0] client_data_idx;
    logic          block_read_trigger, block_read_continous_mode;
    logic [AW-1:0] block_read_block_addr;
    logic          block_read_card_ready = 1'b0;
    logic [7:0]    block_read_data_in = '0;
    logic [LW-1:0] block_read_data_idx = '0;
    logic          block_read_data_new_flag = 1'b0;
    logic [1:0]    owner;
    logic          arb_timeout;

    sd_read_arbiter #(
        .SD_BLOCK_ADDR_BITS  (AW),
        .SD_BLOCK_LENGHT_BITS(LW),
        .GRANT_TIMEOUT       (TO)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .c0_trigger               (c0_trigger),
        .c0_continous_mode        (c0_continous_mode),
        .c0_block_addr            (c0_block_addr),
        .c0_card_ready            (c0_card_ready),
        .c0_data_new_flag         (c0_data_new_flag),
        .c1_trigger               (c1_trigger),
        .c1_continous_mode        (c1_continous_mode),
        .c1_block_addr            (c1_block_addr),
        .c1_card_ready            (c1_card_ready),
        .c1_data_new_flag         (c1_data_new_flag),
        .client_data              (client_data),
        .client_data_idx          (client_data_idx),
        .block_read_trigger       (block_read_trigger),
        .block_read_continous_mode(block_read_continous_mode),
        .block_read_block_addr    (block_read_block_addr),
        .block_read_card_ready    (block_read_card_ready),
        .block_read_data_in       (block_read_data_in),
        .block_read_data_idx      (block_read_data_idx),
        .block_read_data_new_flag (block_read_data_new_flag),
        .owner                    (owner),
        .arb_timeout              (arb_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: who holds the card and whether the card has taken the request.
    int m_holder = -1;
    bit m_accepted = 0;
    int m_wait = 0;
    int m_rr = 0;
    bit m_booted = 0;
    bit m_to = 0;

    task automatic model_step();
        if (rst) begin
            m_holder = -1; m_accepted = 0; m_wait = 0; m_rr = 0; m_booted = 0; m_to = 0;
        end else begin
            bit t0, t1, th;
            t0 = c0_trigger;
            t1 = c1_trigger;
            th = (m_holder == 0) ? t0 : t1;
            if (m_holder < 0) begin
                if (block_read_card_ready && (t0 || t1)) begin
                    m_holder   = (t0 && t1) ? m_rr : (t0 ? 0 : 1);
                    m_accepted = 0;
                    m_wait     = 0;
                end
            end else if (!m_accepted) begin
                if (!block_read_card_ready) begin
                    m_accepted = 1;
                end else if (!th) begin
                    m_holder = -1;
                end else if (m_wait == TO - 1) begin
                    m_holder = -1;
                    m_to     = 1;
                end else begin
                    m_wait++;
                end
            end else if (block_read_card_ready) begin
                m_rr       = 1 - m_holder;
                m_holder   = -1;
                m_accepted = 0;
            end
            if (block_read_card_ready) m_booted = 1;
        end
    endtask

    // Behavioural card reader
    int      card_init_left = 13;
    bit      card_finish = 0;
    bit      card_ignore = 0;
    int      card_acc_wait = 0;
    int      card_lat = 0;
    int      card_byte = 0;
    logic [AW-1:0] card_addr = '0;

    task automatic card_step();
        block_read_data_new_flag = 1'b0;
        if (card_init_left > 0) begin
            card_init_left--;
            if (card_init_left == 0) block_read_card_ready = 1'b1;
        end else if (card_finish) begin
            card_finish = 0;
            block_read_card_ready = 1'b1;
        end else if (block_read_card_ready) begin
            if (block_read_trigger && !card_ignore) begin
                if (card_acc_wait > 0) begin
                    card_acc_wait--;
                end else begin
                    block_read_card_ready = 1'b0;
                    card_acc_wait = $urandom_range(0, 4);
                    card_lat  = $urandom_range(0, 3);
                    card_byte = 0;
                    card_addr = block_read_block_addr;
                end
            end
        end else if (card_lat > 0) begin
            card_lat--;
        end else if ($urandom_range(0, 7) != 0) begin
            block_read_data_new_flag = 1'b1;
            block_read_data_in  = card_addr[7:0] ^ card_byte[7:0];
            block_read_data_idx = card_byte[8:0];
            card_byte++;
            if (card_byte == 512) begin
                if (block_read_continous_mode && block_read_trigger) begin
                    card_addr = card_addr + 1;
                    card_byte = 0;
                    card_lat  = $urandom_range(0, 2);
                end else begin
                    card_finish = 1;
                end
            end
        end
    endtask

    // Client agents
    bit            cl_active[2] = '{0, 0};
    int            cl_cnt[2]    = '{0, 0};
    int            cl_target[2] = '{1, 1};
    bit            cl_cont[2]   = '{0, 0};
    logic [AW-1:0] cl_addr[2];
    int            tot[2]       = '{0, 0};
    bit            rand_en = 0, abandon_en = 0, drop_on_to = 0, rst_req = 1;

    task automatic start_client(input int n, input logic [AW-1:0] a, input bit cont,
                                input int nblk);
        cl_active[n] = 1;
        cl_cnt[n]    = 0;
        cl_cont[n]   = cont;
        cl_addr[n]   = a;
        cl_target[n] = (nblk - 1) * 512 + 1;
    endtask

    task automatic client_step(input logic [1:0] fl, input logic [1:0] rdy, input logic to);
        for (int n = 0; n < 2; n++) begin
            tot[n] += int'(fl[n]);
            if (rst_req) begin
                cl_active[n] = 0;
            end else if (cl_active[n]) begin
                cl_cnt[n] += int'(fl[n]);
                if (cl_cnt[n] >= cl_target[n]) cl_active[n] = 0;
                else if (abandon_en && cl_cnt[n] == 0 && $urandom_range(0, 63) == 0)
                    cl_active[n] = 0;
                else if (drop_on_to && to) cl_active[n] = 0;
            end else if (rand_en && rdy[n] && $urandom_range(0, 199) == 0) begin
                bit c;
                c = ($urandom_range(0, 3) == 0);
                start_client(n, $urandom, c, c ? 2 : 1);
            end
        end
        c0_trigger = cl_active[0]; c0_continous_mode = cl_cont[0]; c0_block_addr = cl_addr[0];
        c1_trigger = cl_active[1]; c1_continous_mode = cl_cont[1]; c1_block_addr = cl_addr[1];
    endtask

    task automatic tick();
        logic [1:0]    e_owner;
        logic          e_trg, e_cm;
        logic [AW-1:0] e_addr;
        logic [1:0]    obs_fl, obs_rdy;
        logic          obs_to;
        @(negedge clk);
        e_owner = (m_holder == 0) ? 2'b01 : (m_holder == 1) ? 2'b10 : 2'b00;
        e_trg   = (m_holder == 0) ? c0_trigger : (m_holder == 1) ? c1_trigger : 1'b0;
        e_cm    = (m_holder == 0) ? c0_continous_mode :
                  (m_holder == 1) ? c1_continous_mode : 1'b0;
        e_addr  = (m_holder == 0) ? c0_block_addr : (m_holder == 1) ? c1_block_addr : '0;
        check_eq("owner", 64'(owner), 64'(e_owner));
        check_eq("arb_timeout", 64'(arb_timeout), 64'(m_to));
        check_eq("c0_ready", 64'(c0_card_ready),
                 64'((m_holder == 0 || !m_booted) ? block_read_card_ready : 1'b1));
        check_eq("c1_ready", 64'(c1_card_ready),
                 64'((m_holder == 1 || !m_booted) ? block_read_card_ready : 1'b1));
        check_eq("c0_flag", 64'(c0_data_new_flag),
                 64'(block_read_data_new_flag && m_holder == 0));
        check_eq("c1_flag", 64'(c1_data_new_flag),
                 64'(block_read_data_new_flag && m_holder == 1));
        check_eq("br_trigger", 64'(block_read_trigger), 64'(e_trg));
        check_eq("br_cont", 64'(block_read_continous_mode), 64'(e_cm));
        check_eq("br_addr", 64'(block_read_block_addr), 64'(e_addr));
        check_eq("data", 64'(client_data), 64'(block_read_data_in));
        check_eq("idx", 64'(client_data_idx), 64'(block_read_data_idx));
        obs_fl  = {c1_data_new_flag, c0_data_new_flag};
        obs_rdy = {c1_card_ready, c0_card_ready};
        obs_to  = arb_timeout;
        card_step();
        client_step(obs_fl, obs_rdy, obs_to);
        rst = rst_req;
        model_step();
    endtask

    task automatic wait_idle(input int budget);
        bit idle = 0;
        for (int i = 0; i < budget && !idle; i++) begin
            tick();
            idle = !cl_active[0] && !cl_active[1] && block_read_card_ready &&
                   card_init_left == 0 && m_holder < 0;
        end
        check_eq("idle_reached", 64'(idle), 64'd1);
    endtask

    initial begin
        int snap;
        bit done;
        rst = 1'b1;
        model_step();
        for (int i = 0; i < 3; i++) tick();
        rst_req = 0;
        // card initialisation window: ready view follows the card
        for (int i = 0; i < 15; i++) tick();

        // single c0 read
        tot = '{0, 0};
        start_client(0, 32'h0000_1000, 0, 1);
        wait_idle(2000);
        check_eq("single_c0_bytes", 64'(tot[0]), 64'd512);
        check_eq("single_c1_bytes", 64'(tot[1]), 64'd0);

        // simultaneous triggers after reset
        rst_req = 1; tick(); rst_req = 0; tick();
        tot = '{0, 0};
        start_client(0, 32'hAAAA_0000, 0, 1);
        start_client(1, 32'h5555_0100, 0, 1);
        wait_idle(4000);
        check_eq("both_c0_bytes", 64'(tot[0]), 64'd512);
        check_eq("both_c1_bytes", 64'(tot[1]), 64'd512);

        // c1 continuous 4 blocks, c0 arrives late and must wait
        tot = '{0, 0};
        start_client(1, 32'h0000_2000, 1, 4);
        for (int i = 0; i < 20; i++) tick();
        start_client(0, 32'h0000_3000, 0, 1);
        wait_idle(8000);
        check_eq("cont_c1_bytes", 64'(tot[1]), 64'd2048);
        check_eq("cont_c0_bytes", 64'(tot[0]), 64'd512);

        // grant timeout: card never accepts
        card_ignore = 1; drop_on_to = 1;
        start_client(0, 32'h0000_4000, 0, 1);
        for (int i = 0; i < 600 && cl_active[0]; i++) tick();
        check_eq("timeout_dropped", 64'(cl_active[0]), 64'd0);
        card_ignore = 0; drop_on_to = 0;
        tot = '{0, 0};
        start_client(1, 32'h0000_5000, 0, 1);
        wait_idle(2000);
        check_eq("after_to_c1_bytes", 64'(tot[1]), 64'd512);
        check_eq("timeout_sticky", 64'(arb_timeout), 64'd1);

        // reset in the middle of a busy transfer
        tot = '{0, 0};
        start_client(1, 32'h0000_6000, 1, 4);
        for (int i = 0; i < 4000 && tot[1] < 100; i++) tick();
        done = (tot[1] >= 100);
        check_eq("reached_byte100", 64'(done), 64'd1);
        rst_req = 1; tick(); rst_req = 0;
        @(posedge clk); #1;
        check_eq("rst_owner", 64'(owner), 64'd0);
        check_eq("rst_trigger", 64'(block_read_trigger), 64'd0);
        check_eq("rst_cont", 64'(block_read_continous_mode), 64'd0);
        check_eq("rst_addr", 64'(block_read_block_addr), 64'd0);
        check_eq("rst_timeout", 64'(arb_timeout), 64'd0);
        snap = tot[1];
        wait_idle(2000);
        check_eq("rst_no_more_c1", 64'(tot[1]), 64'(snap));
        start_client(0, 32'h0000_7000, 0, 1);
        wait_idle(2000);
        check_eq("restart_c0_bytes", 64'(tot[0]), 64'd512);

        // randomized contention with abandons
        rand_en = 1; abandon_en = 1;
        for (int i = 0; i < 20000; i++) tick();
        rand_en = 0;
        wait_idle(20000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
